// File: rtl/tx_frame_serializer_if.sv
// Bundle of the request side and UART byte side of tx_frame_serializer.
//
// Handshake rules:
// - Request side: a rising edge on frame_req asks for one frame.
//   - frame_ack pulses for one cycle when frame_data has been captured.
//   - frame_drop pulses instead when a frame is already in flight.
//   - frame_data must be stable in the cycle the edge is sampled.
// - UART side: byte_en is a one-cycle strobe that the UART uses to latch
//   byte_data. tx_busy high means the UART is transmitting.
//   - A new strobe is only issued after tx_busy has been seen rising for
//     the previous byte and then falling again.
interface tx_frame_serializer_if #(
  parameter int unsigned PAYLOAD_BYTES = 8
);
  logic                         frame_req;
  logic [8*PAYLOAD_BYTES-1:0]   frame_data;
  logic                         tx_busy;
  logic [7:0]                   byte_data;
  logic                         byte_en;
  logic                         frame_busy;
  logic                         frame_ack;
  logic                         frame_done;
  logic                         frame_drop;
  logic                         timeout_err;

  // Control logic plus UART: drives requests and the busy flag
  modport master (
    output frame_req, frame_data, tx_busy,
    input  byte_data, byte_en, frame_busy, frame_ack, frame_done,
           frame_drop, timeout_err
  );

  // Serializer side
  modport slave (
    input  frame_req, frame_data, tx_busy,
    output byte_data, byte_en, frame_busy, frame_ack, frame_done,
           frame_drop, timeout_err
  );
endinterface

// File: rtl/tx_frame_serializer.sv
// Command-frame serializer.
// A request edge captures a payload word. The block then emits
// START_BYTE, the payload bytes (MSB byte first), an optional XOR
// checksum and STOP_BYTE. Each byte is strobed to the UART and paced by
// the UART busy flag, and each byte handshake has an optional timeout.
module tx_frame_serializer #(
  parameter int unsigned PAYLOAD_BYTES = 8,
  parameter logic [7:0]  START_BYTE    = 8'hC0,
  parameter logic [7:0]  STOP_BYTE     = 8'hCF,
  parameter bit          CSUM_EN       = 1'b1,
  parameter logic [15:0] TIMEOUT_CYC   = 16'd50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tx_frame_serializer_if.slave  bus,
  output logic [1:0]            state_o
);

  localparam int unsigned FRAME_LEN = PAYLOAD_BYTES + (CSUM_EN ? 3 : 2);
  localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] PAY_IDX  = IDX_W'(PAYLOAD_BYTES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_HI = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  state_t                       state_q;
  logic                         req_d1_q;
  logic [8*PAYLOAD_BYTES-1:0]   shift_q;
  logic [7:0]                   csum_q;
  logic [IDX_W-1:0]             idx_q;
  logic [15:0]                  tmo_q;
  logic [7:0]                   byte_data_q;
  logic                         byte_en_q;
  logic                         busy_q;
  logic                         ack_q;
  logic                         done_q;
  logic                         drop_q;
  logic                         tmo_err_q;

  logic                         req_edge;
  logic                         tmo_hit;
  logic                         is_payload;
  logic [7:0]                   issue_byte_d;

  assign req_edge   = bus.frame_req & ~req_d1_q;
  // The counter is loaded with TIMEOUT_CYC at the strobe and decremented
  // once per wait cycle. Seeing 1 therefore marks the TIMEOUT_CYC-th wait
  // cycle after the strobe.
  assign tmo_hit    = (TIMEOUT_CYC != 16'd0) && (tmo_q == 16'd1);
  assign is_payload = (idx_q != '0) && (idx_q <= PAY_IDX);

  // Select the byte for the current frame position
  always_comb begin
    issue_byte_d = STOP_BYTE;
    if (idx_q == '0) begin
      issue_byte_d = START_BYTE;
    end else if (is_payload) begin
      issue_byte_d = shift_q[8*PAYLOAD_BYTES-1 -: 8];
    end else if (CSUM_EN && (idx_q != LAST_IDX)) begin
      issue_byte_d = csum_q;
    end
  end

  // Frame sequencer with registered outputs; pulses default low each cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_d1_q    <= 1'b0;
      shift_q     <= '0;
      csum_q      <= 8'h00;
      idx_q       <= '0;
      tmo_q       <= 16'd0;
      byte_data_q <= 8'h00;
      byte_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      req_d1_q  <= bus.frame_req;
      byte_en_q <= 1'b0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      tmo_err_q <= 1'b0;
      // Edges arriving while a frame is in flight are reported, not queued
      drop_q    <= req_edge && busy_q;

      case (state_q)
        S_IDLE: begin
          if (req_edge) begin
            shift_q <= bus.frame_data;
            csum_q  <= 8'h00;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            ack_q   <= 1'b1;
            state_q <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (!bus.tx_busy) begin
            byte_data_q <= issue_byte_d;
            byte_en_q   <= 1'b1;
            tmo_q       <= TIMEOUT_CYC;
            if (is_payload) begin
              shift_q <= shift_q << 8;
              csum_q  <= csum_q ^ issue_byte_d;
            end
            state_q <= S_WAIT_HI;
          end
        end

        S_WAIT_HI: begin
          if (tmo_hit) begin
            tmo_err_q   <= 1'b1;
            busy_q      <= 1'b0;
            byte_data_q <= 8'h00;
            tmo_q       <= 16'd0;
            state_q     <= S_IDLE;
          end else begin
            if (tmo_q != 16'd0) tmo_q <= tmo_q - 16'd1;
            if (bus.tx_busy) state_q <= S_WAIT_LO;
          end
        end

        S_WAIT_LO: begin
          if (tmo_hit) begin
            tmo_err_q   <= 1'b1;
            busy_q      <= 1'b0;
            byte_data_q <= 8'h00;
            tmo_q       <= 16'd0;
            state_q     <= S_IDLE;
          end else begin
            if (tmo_q != 16'd0) tmo_q <= tmo_q - 16'd1;
            if (!bus.tx_busy) begin
              if (idx_q == LAST_IDX) begin
                done_q      <= 1'b1;
                busy_q      <= 1'b0;
                byte_data_q <= 8'h00;
                tmo_q       <= 16'd0;
                state_q     <= S_IDLE;
              end else begin
                idx_q   <= idx_q + 1'b1;
                state_q <= S_ISSUE;
              end
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.byte_data   = byte_data_q;
  assign bus.byte_en     = byte_en_q;
  assign bus.frame_busy  = busy_q;
  assign bus.frame_ack   = ack_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_drop  = drop_q;
  assign bus.timeout_err = tmo_err_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Bench for tx_frame_serializer with three configurations:
//   a: P=8, checksum, timeout 20
//   b: P=2, no checksum, A5/5A delimiters
//   c: P=1, checksum, timeout 20
module tb_tx_frame_serializer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  tx_frame_serializer_if #(.PAYLOAD_BYTES(8)) bus_a ();
  tx_frame_serializer_if #(.PAYLOAD_BYTES(2)) bus_b ();
  tx_frame_serializer_if #(.PAYLOAD_BYTES(1)) bus_c ();
  logic [1:0] state_a, state_b, state_c;

  tx_frame_serializer #(
    .PAYLOAD_BYTES(8), .START_BYTE(8'hC0), .STOP_BYTE(8'hCF),
    .CSUM_EN(1'b1), .TIMEOUT_CYC(16'd20)
  ) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .state_o(state_a));

  tx_frame_serializer #(
    .PAYLOAD_BYTES(2), .START_BYTE(8'hA5), .STOP_BYTE(8'h5A),
    .CSUM_EN(1'b0), .TIMEOUT_CYC(16'd50000)
  ) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .state_o(state_b));

  tx_frame_serializer #(
    .PAYLOAD_BYTES(1), .START_BYTE(8'hC0), .STOP_BYTE(8'hCF),
    .CSUM_EN(1'b1), .TIMEOUT_CYC(16'd20)
  ) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave), .state_o(state_c));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- UART models: busy 10 cycles per strobe ----------------
  logic hold_a, hold_b, hold_c;
  int   cnt_a, cnt_b, cnt_c;
  assign bus_a.tx_busy = hold_a | (cnt_a != 0);
  assign bus_b.tx_busy = hold_b | (cnt_b != 0);
  assign bus_c.tx_busy = hold_c | (cnt_c != 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= 0; cnt_b <= 0; cnt_c <= 0;
    end else begin
      if (bus_a.byte_en) cnt_a <= 10; else if (cnt_a != 0) cnt_a <= cnt_a - 1;
      if (bus_b.byte_en) cnt_b <= 10; else if (cnt_b != 0) cnt_b <= cnt_b - 1;
      if (bus_c.byte_en) cnt_c <= 10; else if (cnt_c != 0) cnt_c <= cnt_c - 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_a_q[$];
  logic [7:0] exp_b_q[$];
  logic [7:0] exp_c_q[$];
  int ack_a, done_a, drop_a, tmo_a;
  int ack_c, done_c, tmo_c;

  always @(negedge clk) begin
    logic [7:0] e;
    if (bus_a.byte_en) begin
      checks++;
      if (exp_a_q.size() == 0) begin
        errors++;
        $display("FAIL a_byte: got unexpected byte %02h, required no strobe", bus_a.byte_data);
      end else begin
        e = exp_a_q.pop_front();
        if (bus_a.byte_data !== e) begin
          errors++;
          $display("FAIL a_byte: got %02h, required %02h", bus_a.byte_data, e);
        end
      end
    end
    if (bus_b.byte_en) begin
      checks++;
      if (exp_b_q.size() == 0) begin
        errors++;
        $display("FAIL b_byte: got unexpected byte %02h, required no strobe", bus_b.byte_data);
      end else begin
        e = exp_b_q.pop_front();
        if (bus_b.byte_data !== e) begin
          errors++;
          $display("FAIL b_byte: got %02h, required %02h", bus_b.byte_data, e);
        end
      end
    end
    if (bus_c.byte_en) begin
      checks++;
      if (exp_c_q.size() == 0) begin
        errors++;
        $display("FAIL c_byte: got unexpected byte %02h, required no strobe", bus_c.byte_data);
      end else begin
        e = exp_c_q.pop_front();
        if (bus_c.byte_data !== e) begin
          errors++;
          $display("FAIL c_byte: got %02h, required %02h", bus_c.byte_data, e);
        end
      end
    end
    if (bus_a.frame_ack)   ack_a++;
    if (bus_a.frame_done)  done_a++;
    if (bus_a.frame_drop)  drop_a++;
    if (bus_a.timeout_err) tmo_a++;
    if (bus_c.frame_ack)   ack_c++;
    if (bus_c.frame_done)  done_c++;
    if (bus_c.timeout_err) tmo_c++;
  end

  // ---------------- driver tasks ----------------
  // Reference frame for instance a: START, bytes MSB first, XOR, STOP
  task automatic push_frame_a(input logic [63:0] d);
    logic [7:0] b;
    logic [7:0] cs;
    cs = 8'h00;
    exp_a_q.push_back(8'hC0);
    for (int i = 7; i >= 0; i--) begin
      b = d[8*i +: 8];
      cs = cs ^ b;
      exp_a_q.push_back(b);
    end
    exp_a_q.push_back(cs);
    exp_a_q.push_back(8'hCF);
  endtask

  task automatic pulse_req_a();
    @(negedge clk); bus_a.frame_req = 1'b1;
    @(negedge clk); bus_a.frame_req = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus_a.frame_done) seen = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus_a.frame_req = 0; bus_b.frame_req = 0; bus_c.frame_req = 0;
    bus_a.frame_data = '0; bus_b.frame_data = '0; bus_c.frame_data = '0;
    hold_a = 0; hold_b = 0; hold_c = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_a.byte_data, bus_a.byte_en, bus_a.frame_busy, bus_a.frame_ack, bus_a.frame_done,
         bus_a.frame_drop, bus_a.timeout_err, state_a} !== 16'h0) begin
      errors++;
      $display("FAIL reset_a: got %04h, required 0000",
        {bus_a.byte_data, bus_a.byte_en, bus_a.frame_busy, bus_a.frame_ack, bus_a.frame_done,
         bus_a.frame_drop, bus_a.timeout_err, state_a});
    end
    checks++;
    if ({bus_b.byte_data, bus_b.byte_en, bus_b.frame_busy, bus_b.frame_ack, bus_b.frame_done,
         bus_b.frame_drop, bus_b.timeout_err, state_b} !== 16'h0) begin
      errors++;
      $display("FAIL reset_b: got nonzero outputs, required 0000");
    end
    checks++;
    if ({bus_c.byte_data, bus_c.byte_en, bus_c.frame_busy, bus_c.frame_ack, bus_c.frame_done,
         bus_c.frame_drop, bus_c.timeout_err, state_c} !== 16'h0) begin
      errors++;
      $display("FAIL reset_c: got nonzero outputs, required 0000");
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_csum_frame();
    logic [7:0] tbl [11];
    bit seen;
    tbl = '{8'hC0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88, 8'hCF};
    ack_a = 0; done_a = 0; drop_a = 0; tmo_a = 0;
    bus_a.frame_data = 64'h1122334455667788;
    foreach (tbl[i]) exp_a_q.push_back(tbl[i]);
    @(negedge clk); bus_a.frame_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus_a.frame_ack, bus_a.frame_busy} !== 2'b11) begin
      errors++;
      $display("FAIL csum_accept: got ack/busy %b, required 11", {bus_a.frame_ack, bus_a.frame_busy});
    end
    bus_a.frame_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_a.byte_en !== 1'b1) begin
      errors++;
      $display("FAIL csum_first_strobe: got byte_en %b, required 1", bus_a.byte_en);
    end
    wait_done_a(400, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL csum_done: got no frame_done, required one"); end
    @(negedge clk);
    checks++;
    if (ack_a !== 1 || done_a !== 1 || exp_a_q.size() !== 0 || bus_a.frame_busy !== 1'b0) begin
      errors++;
      $display("FAIL csum_counts: got ack %0d done %0d left %0d busy %b, required 1 1 0 0",
        ack_a, done_a, exp_a_q.size(), bus_a.frame_busy);
    end
  endtask

  task automatic test_short_frame();
    bit seen, busy_gap;
    exp_b_q.push_back(8'hA5); exp_b_q.push_back(8'hBE);
    exp_b_q.push_back(8'hEF); exp_b_q.push_back(8'h5A);
    bus_b.frame_data = 16'hBEEF;
    @(negedge clk); bus_b.frame_req = 1'b1;
    @(negedge clk); bus_b.frame_req = 1'b0;
    checks++;
    if (bus_b.frame_ack !== 1'b1) begin
      errors++; $display("FAIL short_ack: got %b, required 1", bus_b.frame_ack);
    end
    seen = 0; busy_gap = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus_b.frame_done) seen = 1;
      else if (bus_b.frame_busy !== 1'b1) busy_gap = 1;
    end
    checks++;
    if (!seen || busy_gap) begin
      errors++; $display("FAIL short_busy: got done %b gap %b, required 1 0", seen, busy_gap);
    end
    checks++;
    if (bus_b.frame_busy !== 1'b0) begin
      errors++; $display("FAIL short_busy_at_done: got %b, required 0", bus_b.frame_busy);
    end
    checks++;
    if (exp_b_q.size() !== 0) begin
      errors++; $display("FAIL short_bytes: got %0d missing bytes, required 0", exp_b_q.size());
    end
  endtask

  task automatic test_repeated_req();
    logic [63:0] d;
    bit seen;
    // Level held high: one frame only
    ack_a = 0; done_a = 0; drop_a = 0;
    d = {$urandom, $urandom};
    bus_a.frame_data = d;
    push_frame_a(d);
    @(negedge clk); bus_a.frame_req = 1'b1;
    repeat (500) @(negedge clk);
    bus_a.frame_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ack_a !== 1 || done_a !== 1 || drop_a !== 0 || exp_a_q.size() !== 0) begin
      errors++;
      $display("FAIL level_req: got ack %0d done %0d drop %0d left %0d, required 1 1 0 0",
        ack_a, done_a, drop_a, exp_a_q.size());
    end
    // Edge mid-frame is dropped; edge right after done is accepted
    ack_a = 0; done_a = 0; drop_a = 0;
    d = {$urandom, $urandom};
    bus_a.frame_data = d;
    push_frame_a(d);
    pulse_req_a();
    repeat (30) @(negedge clk);
    bus_a.frame_req = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_a.frame_drop !== 1'b1) begin
      errors++; $display("FAIL drop_pulse: got %b, required 1", bus_a.frame_drop);
    end
    bus_a.frame_req = 1'b0;
    wait_done_a(400, seen);
    d = {$urandom, $urandom};
    bus_a.frame_data = d;
    push_frame_a(d);
    bus_a.frame_req = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_a.frame_ack !== 1'b1 || bus_a.frame_drop !== 1'b0) begin
      errors++;
      $display("FAIL req_after_done: got ack %b drop %b, required 1 0", bus_a.frame_ack, bus_a.frame_drop);
    end
    bus_a.frame_req = 1'b0;
    wait_done_a(400, seen);
    @(negedge clk);
    checks++;
    if (!seen || ack_a !== 2 || done_a !== 2 || drop_a !== 1 || exp_a_q.size() !== 0) begin
      errors++;
      $display("FAIL drop_counts: got ack %0d done %0d drop %0d left %0d, required 2 2 1 0",
        ack_a, done_a, drop_a, exp_a_q.size());
    end
  endtask

  task automatic test_timeout();
    logic [63:0] d;
    bit seen;
    int n;
    done_a = 0; tmo_a = 0;
    bus_a.frame_data = {$urandom, $urandom};
    exp_a_q.push_back(8'hC0);
    pulse_req_a();
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus_a.byte_en) seen = 1;
    end
    hold_a = 1'b1;
    n = 0; seen = 0;
    while (n < 60 && !seen) begin
      @(negedge clk);
      n++;
      if (bus_a.timeout_err) seen = 1;
    end
    checks++;
    if (!seen || n != 20) begin
      errors++; $display("FAIL timeout_latency: got %0d cycles (seen %b), required 20", n, seen);
    end
    checks++;
    if (bus_a.frame_busy !== 1'b0) begin
      errors++; $display("FAIL timeout_busy: got %b, required 0", bus_a.frame_busy);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done_a !== 0 || tmo_a !== 1 || exp_a_q.size() !== 0) begin
      errors++;
      $display("FAIL timeout_counts: got done %0d tmo %0d left %0d, required 0 1 0",
        done_a, tmo_a, exp_a_q.size());
    end
    hold_a = 1'b0;
    repeat (15) @(negedge clk);
    d = {$urandom, $urandom};
    bus_a.frame_data = d;
    push_frame_a(d);
    pulse_req_a();
    wait_done_a(400, seen);
    @(negedge clk);
    checks++;
    if (!seen || done_a !== 1 || tmo_a !== 1 || exp_a_q.size() !== 0) begin
      errors++;
      $display("FAIL timeout_recover: got done %0d tmo %0d left %0d, required 1 1 0",
        done_a, tmo_a, exp_a_q.size());
    end
  endtask

  task automatic test_busy_at_start();
    logic [7:0] d;
    bit seen;
    ack_c = 0; done_c = 0; tmo_c = 0;
    d = 8'($urandom_range(0, 255));
    bus_c.frame_data = d;
    exp_c_q.push_back(8'hC0); exp_c_q.push_back(d);
    exp_c_q.push_back(d);     exp_c_q.push_back(8'hCF);
    hold_c = 1'b1;
    @(negedge clk); bus_c.frame_req = 1'b1;
    @(negedge clk); bus_c.frame_req = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (state_c !== 2'd1 || exp_c_q.size() !== 4 || tmo_c !== 0 || bus_c.frame_busy !== 1'b1) begin
      errors++;
      $display("FAIL start_wait: got state %0d left %0d tmo %0d busy %b, required 1 4 0 1",
        state_c, exp_c_q.size(), tmo_c, bus_c.frame_busy);
    end
    hold_c = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus_c.frame_done) seen = 1;
    end
    @(negedge clk);
    checks++;
    if (!seen || done_c !== 1 || ack_c !== 1 || exp_c_q.size() !== 0) begin
      errors++;
      $display("FAIL start_release: got done %0d ack %0d left %0d, required 1 1 0",
        done_c, ack_c, exp_c_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] d;
    bit seen;
    d = {$urandom, $urandom};
    bus_a.frame_data = d;
    push_frame_a(d);
    pulse_req_a();
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (exp_a_q.size() == 6) seen = 1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (!seen || {bus_a.byte_data, bus_a.byte_en, bus_a.frame_busy, bus_a.frame_ack,
                  bus_a.frame_done, bus_a.frame_drop, bus_a.timeout_err, state_a} !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid: got reached %b outputs %04h, required 1 0000", seen,
        {bus_a.byte_data, bus_a.byte_en, bus_a.frame_busy, bus_a.frame_ack,
         bus_a.frame_done, bus_a.frame_drop, bus_a.timeout_err, state_a});
    end
    exp_a_q.delete();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    done_a = 0;
    d = {$urandom, $urandom};
    bus_a.frame_data = d;
    push_frame_a(d);
    pulse_req_a();
    wait_done_a(400, seen);
    @(negedge clk);
    checks++;
    if (!seen || done_a !== 1 || exp_a_q.size() !== 0) begin
      errors++;
      $display("FAIL reset_fresh_frame: got done %0d left %0d, required 1 0", done_a, exp_a_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_csum_frame();
    test_short_frame();
    test_repeated_req();
    test_timeout();
    test_busy_at_start();
    test_reset_mid_frame();
    repeat (20) @(negedge clk);
    checks++;
    if (exp_a_q.size() + exp_b_q.size() + exp_c_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_bytes: got %0d, required 0",
        exp_a_q.size() + exp_b_q.size() + exp_c_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
